// File: rtl/ecc_job_sequencer.sv
// Purpose: queues (point, scalar) jobs and runs the ECC engine start/done handshake one job at a time.
// Latency: push to eng_start is 2 edges; eng_done to res_valid is 2 edges; push to res_valid is 4 edges plus engine time.
// Backpressure: job_ready = FIFO not full; a held result (res_ready low) stalls issue, so the FIFO fills.
//
// Ports:
//   clk, rst                          clock; asynchronous active-high reset
//   job_valid/job_ready, job_x/y/scalar  request side, pushed into a FIFO_DEPTH-entry queue
//   eng_start, eng_point_x/y, eng_scalar engine command: one-cycle start pulse, operands held until next pop
//   eng_done, eng_result_x/y          engine completion pulse; result valid the cycle after eng_done
//   res_valid/res_ready, res_x/y, res_tag, res_timeout  result side, registered valid/ready
//   busy                              sequencer not idle or jobs still queued
//
// Build option: define ECC_SEQ_TIMEOUT_EN to add a wait watchdog of TIMEOUT_CYCLES cycles
// (TIMEOUT_CYCLES must be >= 2). Without it the sequencer waits for eng_done indefinitely.
module ecc_job_sequencer #(
    parameter int FIELD_WIDTH    = 16,
    parameter int SCALAR_WIDTH   = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [FIELD_WIDTH-1:0]  job_x,
    input  logic [FIELD_WIDTH-1:0]  job_y,
    input  logic [SCALAR_WIDTH-1:0] job_scalar,
    output logic                    eng_start,
    output logic [FIELD_WIDTH-1:0]  eng_point_x,
    output logic [FIELD_WIDTH-1:0]  eng_point_y,
    output logic [SCALAR_WIDTH-1:0] eng_scalar,
    input  logic                    eng_done,
    input  logic [FIELD_WIDTH-1:0]  eng_result_x,
    input  logic [FIELD_WIDTH-1:0]  eng_result_y,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [FIELD_WIDTH-1:0]  res_x,
    output logic [FIELD_WIDTH-1:0]  res_y,
    output logic [7:0]              res_tag,
    output logic                    res_timeout,
    output logic                    busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_OUTPUT  = 3'd4;

    typedef struct packed {
        logic [SCALAR_WIDTH-1:0] k;
        logic [FIELD_WIDTH-1:0]  y;
        logic [FIELD_WIDTH-1:0]  x;
    } job_t;

    logic [2:0]   state;
    logic [7:0]   tag_ctr;
    logic         expired;

    // ---------------------------------------------------------------
    // Job FIFO: pointers carry one extra wrap bit to tell full from empty.
    // ---------------------------------------------------------------
    job_t         fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic         fifo_empty;
    logic         fifo_full;
    logic         push;
    logic         pop;
    job_t         head;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    // Full blocks the push even when a pop happens in the same cycle.
    assign job_ready  = !fifo_full;
    assign push       = job_valid && job_ready;
    assign pop        = (state == ST_IDLE) && !fifo_empty;
    assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];

    // Storage is data only; reset clears the pointers, which empties the queue.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= '{k: job_scalar, y: job_y, x: job_x};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Optional wait watchdog.
    // ---------------------------------------------------------------
`ifdef ECC_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);

    logic [TO_W-1:0] to_cnt;
    logic            to_flag;

    // Counter holds k during the (k+1)-th WAIT cycle, so expiry lands on
    // WAIT cycle TIMEOUT_CYCLES.
    assign expired     = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign res_timeout = to_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else begin
            if (state == ST_ISSUE) begin
                to_cnt <= '0;
            end else if (state == ST_WAIT && !eng_done && !expired) begin
                to_cnt <= to_cnt + 1'b1;
            end

            // eng_done in the expiry cycle wins and takes the normal capture path.
            if (state == ST_WAIT && !eng_done && expired) begin
                to_flag <= 1'b1;
            end else if (state == ST_CAPTURE) begin
                to_flag <= 1'b0;
            end
        end
    end
`else
    // No watchdog: never expires. The parameter term is constant-false and
    // only keeps the unused parameter referenced in this build.
    assign expired     = 1'b0 && (TIMEOUT_CYCLES > 0);
    assign res_timeout = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Sequencer FSM
    // ---------------------------------------------------------------
    assign eng_start = (state == ST_ISSUE);
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            tag_ctr     <= 8'd0;
            eng_point_x <= '0;
            eng_point_y <= '0;
            eng_scalar  <= '0;
            res_x       <= '0;
            res_y       <= '0;
            res_tag     <= 8'd0;
            res_valid   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        eng_point_x <= head.x;
                        eng_point_y <= head.y;
                        eng_scalar  <= head.k;
                        res_tag     <= tag_ctr;
                        tag_ctr     <= tag_ctr + 8'd1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eng_done) begin
                        state <= ST_CAPTURE;
                    end else if (expired) begin
                        res_x     <= '0;
                        res_y     <= '0;
                        res_valid <= 1'b1;
                        state     <= ST_OUTPUT;
                    end
                end
                ST_CAPTURE: begin
                    // Engine result is registered on its side and valid now.
                    res_x     <= eng_result_x;
                    res_y     <= eng_result_y;
                    res_valid <= 1'b1;
                    state     <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_job_sequencer.sv
// Purpose: self-checking bench for ecc_job_sequencer with a queue-based job/result model and engine model.
// Latency: engine model raises done eng_delay WAIT cycles after start and drives the result one cycle later.
// Backpressure: res_ready and engine stall are driven by directed tests.
module tb_ecc_job_sequencer;

    localparam int T = 16;
`ifdef ECC_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [15:0] job_x = '0, job_y = '0, job_scalar = '0;
    logic        eng_start;
    logic [15:0] eng_point_x, eng_point_y, eng_scalar;
    logic        eng_done = 1'b0;
    logic [15:0] eng_result_x = '0, eng_result_y = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [15:0] res_x, res_y;
    logic [7:0]  res_tag;
    logic        res_timeout;
    logic        busy;

    ecc_job_sequencer #(
        .FIELD_WIDTH(16), .SCALAR_WIDTH(16), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_x(job_x), .job_y(job_y), .job_scalar(job_scalar),
        .eng_start(eng_start), .eng_point_x(eng_point_x), .eng_point_y(eng_point_y),
        .eng_scalar(eng_scalar), .eng_done(eng_done),
        .eng_result_x(eng_result_x), .eng_result_y(eng_result_y),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_x(res_x), .res_y(res_y), .res_tag(res_tag),
        .res_timeout(res_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] x, y, k; logic [7:0] tag; } job_s;
    typedef struct { logic [15:0] x, y; logic [7:0] tag; logic to; } res_s;

    int checks = 0;
    int errors = 0;

    // Model state
    job_s pend[$];          // accepted, not yet started
    res_s expq[$];          // results the DUT owes, in order
    job_s cur;
    logic [7:0] tag_ctr = 8'd0;
    bit   outstanding = 0;
    int   start_count = 0;
    int   hs_count = 0;
    logic [7:0] tags_seen[$];
    res_s last_res;

    // Engine model controls
    int   eng_delay = 5;
    bit   eng_stall = 0;
    bit   eng_spur = 0;
    bit   fixed_res = 0;
    bit   eng_act = 0;
    int   eng_cnt = 0;
    int   waited = 0;
    bit   done_prev = 0;
    logic [15:0] eng_rx = '0, eng_ry = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name, input int act, input int exp);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Compare process plus engine model, all at the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            pend.delete();
            expq.delete();
            outstanding = 0;
            tag_ctr     = 8'd0;
            eng_act     = 0;
            done_prev   = 0;
            eng_done    = 1'b0;
        end else begin
            chk("busy", busy, (outstanding || pend.size() != 0));

            if (eng_start) begin
                start_count++;
                chk("start_while_result_pending", outstanding, 0);
                if (pend.size() == 0) begin
                    flag_fail("start_without_job", 1, 0);
                end else begin
                    cur = pend.pop_front();
                    chk("eng_point_x", eng_point_x, cur.x);
                    chk("eng_point_y", eng_point_y, cur.y);
                    chk("eng_scalar", eng_scalar, cur.k);
                    outstanding = 1;
                    eng_act     = 1;
                    waited      = 0;
                    eng_cnt     = eng_delay;
                end
            end

            if (res_valid) begin
                if (expq.size() == 0) begin
                    flag_fail("res_valid_without_job", 1, 0);
                end else begin
                    chk("res_x", res_x, expq[0].x);
                    chk("res_y", res_y, expq[0].y);
                    chk("res_tag", res_tag, expq[0].tag);
                    chk("res_timeout", res_timeout, expq[0].to);
                    if (res_ready) begin
                        last_res = expq.pop_front();
                        tags_seen.push_back(res_tag);
                        outstanding = 0;
                        hs_count++;
                    end
                end
            end

            if (job_valid && job_ready) begin
                pend.push_back('{x: job_x, y: job_y, k: job_scalar, tag: tag_ctr});
                tag_ctr = tag_ctr + 8'd1;
            end

            // Engine: result on the bus only in the cycle after done.
            eng_result_x = done_prev ? eng_rx : 16'hdead;
            eng_result_y = done_prev ? eng_ry : 16'hbeef;
            done_prev    = 0;
            eng_done     = eng_spur;
            if (eng_act && !eng_start) begin
                waited++;
                if (!eng_stall) eng_cnt--;
                if (!eng_stall && eng_cnt <= 0) begin
                    res_s r;
                    eng_done  = 1'b1;
                    done_prev = 1;
                    eng_rx = fixed_res ? 16'h1234 : cur.x + cur.k;
                    eng_ry = fixed_res ? 16'h5678 : cur.y - cur.k;
                    r = '{x: eng_rx, y: eng_ry, tag: cur.tag, to: 1'b0};
                    expq.push_back(r);
                    eng_act = 0;
                end else if (TO_EN && waited == T) begin
                    expq.push_back('{x: 16'h0, y: 16'h0, tag: cur.tag, to: 1'b1});
                    eng_act = 0;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_job(input logic [15:0] x, input logic [15:0] y, input logic [15:0] k);
        int n = 0;
        job_valid = 1'b1; job_x = x; job_y = y; job_scalar = k;
        do begin @(negedge clk); n++; end while (!job_ready && n < 500);
        if (!job_ready) flag_fail("push_timeout", n, 500);
        @(posedge clk); #1;
        job_valid = 1'b0;
    endtask

    task automatic wait_hs(input int target, input int budget);
        int n = 0;
        while (hs_count < target && n < budget) begin @(negedge clk); n++; end
        if (hs_count < target) flag_fail("wait_results", hs_count, target);
        @(posedge clk); #1;
    endtask

    task automatic wait_res_valid(input int budget);
        int n = 0;
        do begin @(negedge clk); n++; end while (!res_valid && n < budget);
        if (!res_valid) flag_fail("wait_res_valid", n, budget);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    int sc, tb0;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_job_ready", job_ready, 1);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_tag", res_tag, 0);
        chk("rst_res_x", res_x, 0);
        chk("rst_eng_point_x", eng_point_x, 0);
        chk("rst_res_timeout", res_timeout, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single job with fixed engine result
        fixed_res = 1; eng_delay = 5; res_ready = 1'b1;
        sc = start_count;
        push_job(16'h0003, 16'h0005, 16'h0001);
        wait_res_valid(50);
        chk("t1_res_x", res_x, 16'h1234);
        chk("t1_res_y", res_y, 16'h5678);
        chk("t1_res_tag", res_tag, 8'd0);
        chk("t1_res_timeout", res_timeout, 0);
        wait_hs(1, 20);
        repeat (3) @(negedge clk);
        chk("t1_start_pulses", start_count - sc, 1);
        fixed_res = 0;

        // Five jobs into a stalled engine: FIFO full after the fifth push
        do_reset();
        eng_stall = 1; eng_delay = 3;
        tb0 = tags_seen.size();
        for (int i = 0; i < 5; i++) push_job(16'(16'h0010 * i), 16'(16'h0200 + i), 16'(i + 1));
        @(negedge clk);
        chk("t2_job_ready_full", job_ready, 0);
        chk("t2_busy", busy, 1);
        @(posedge clk); #1 eng_stall = 0;
        wait_hs(hs_count + 5, 200);
        for (int i = 0; i < 5; i++) begin
            logic [7:0] t;
            t = (tags_seen.size() > tb0 + i) ? tags_seen[tb0 + i] : 8'hff;
            chk("t2_tag_order", t, 8'(i));
        end

        // Result held for 10 cycles: stable outputs, no new start
        res_ready = 1'b0; eng_delay = 2;
        push_job(16'h0100, 16'h0200, 16'h0011);
        push_job(16'h0300, 16'h0400, 16'h0022);
        wait_res_valid(50);
        sc = start_count;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", res_valid, 1);
            chk("t3_hold_x", res_x, 16'h0111);
            chk("t3_hold_y", res_y, 16'h01ef);
        end
        chk("t3_no_start_while_held", start_count - sc, 0);
        @(posedge clk); #1 res_ready = 1'b1;
        wait_hs(hs_count + 2, 50);
        chk("t3_second_x", last_res.x, 16'h0322);

        // eng_done while idle is ignored
        eng_spur = 1;
        @(posedge clk); #1 eng_spur = 0;
        repeat (3) @(negedge clk);
        chk("spur_busy", busy, 0);
        chk("spur_res_valid", res_valid, 0);
        @(posedge clk); #1;

        // Long engine time: timeout with the watchdog, plain wait without it
        eng_delay = 40;
        push_job(16'h0a00, 16'h0b00, 16'h0005);
        wait_hs(hs_count + 1, 100);
        chk("long_timeout_flag", last_res.to, TO_EN);
        chk("long_res_x", last_res.x, TO_EN ? 16'h0000 : 16'h0a05);
        // Done exactly on the expiry cycle: normal capture
        eng_delay = T;
        push_job(16'h0c00, 16'h0d00, 16'h0006);
        wait_hs(hs_count + 1, 100);
        chk("edge_timeout_flag", last_res.to, 0);
        chk("edge_res_y", last_res.y, 16'h0cfa);
        // One cycle past expiry
        eng_delay = T + 1;
        push_job(16'h0e00, 16'h0f00, 16'h0000);
        wait_hs(hs_count + 1, 100);
        chk("past_timeout_flag", last_res.to, TO_EN);

        // Reset during WAIT with two jobs queued
        eng_stall = 1; eng_delay = 2;
        push_job(16'h1111, 16'h2222, 16'h0001);
        push_job(16'h3333, 16'h4444, 16'h0002);
        push_job(16'h5555, 16'h6666, 16'h0003);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_job_ready", job_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_eng_start", eng_start, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_point_x", eng_point_x, 0);
        chk("mid_rst_scalar", eng_scalar, 0);
        chk("mid_rst_res_tag", res_tag, 0);
        sc = start_count;
        @(posedge clk); #1 rst = 1'b0; eng_stall = 0;
        repeat (20) @(negedge clk);
        chk("no_start_after_rst", start_count - sc, 0);
        @(posedge clk); #1;

        // 257 jobs: tags 0..255 then wrap to 0
        eng_delay = 1; res_ready = 1'b1;
        tb0 = tags_seen.size();
        sc = hs_count;
        for (int i = 0; i < 257; i++) push_job(16'(i), 16'(~i), 16'(3 * i));
        wait_hs(sc + 257, 3000);
        chk("wrap_tag_255", (tags_seen.size() > tb0 + 255) ? tags_seen[tb0 + 255] : 8'h00, 8'd255);
        chk("wrap_tag_0", (tags_seen.size() > tb0 + 256) ? tags_seen[tb0 + 256] : 8'hff, 8'd0);

        repeat (3) @(negedge clk);
        chk("end_queues_empty", pend.size() + expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "simulation time limit");
    end

endmodule
